// File: rtl/axi3_mst_read.sv
// AXI3 read master: fetches data_len bytes from addr_src in INCR16/8/4/single
// bursts and streams the returned words into the CRC sync-FIFO.
`timescale 1ns/1ps
module axi3_mst_read #(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr_src,
    input  logic [15:0]           data_len,
    input  logic                  mst_begin,
    output logic                  busy,
    output logic                  rd_done,
    output logic                  error,
    input  logic                  fifo_full,
    output logic                  fifo_wr,
    output logic [DATA_WIDTH-1:0] fifo_wdata,
    output logic                  fifo_last,
    output logic [2:0]            fifo_bytes,
    input  logic                  arready,
    output logic [3:0]            arid,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic [3:0]            arlen,
    output logic [2:0]            arsize,
    output logic [1:0]            arburst,
    output logic [1:0]            arlock,
    output logic [3:0]            arcache,
    output logic [2:0]            arprot,
    output logic                  arvalid,
    input  logic [3:0]            rid,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            rresp,
    input  logic                  rlast,
    input  logic                  rvalid,
    output logic                  rready
);

    localparam int unsigned WORD_W  = 15;
    localparam int unsigned OUT_W   = 3;
    localparam int unsigned CNT16_W = 11;
    localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_WAIT, S_FIN} state_t;

    state_t                 state_q;
    logic                   busy_q, rd_done_q, error_q, arvalid_q;
    logic [ADDR_WIDTH-1:0]  araddr_q;
    logic [3:0]             arlen_q;
    logic [2:0]             arsize_q;
    logic [1:0]             arburst_q;
    logic [OUT_W-1:0]       out_q, out_d;
    logic [CNT16_W-1:0]     n16_q, n16_d;
    logic                   n8_q, n8_d, n4_q, n4_d;
    logic [1:0]             n1_q, n1_d;
    logic [WORD_W-1:0]      words_q, beats_q;
    logic [2:0]             tail_q;

    logic [16:0]            len_p3;
    logic [WORD_W-1:0]      words_c;
    logic [4:0]             burst_beats;
    logic                   ar_hs, rready_c, wr_c, r_end, last_c, more_d;
    logic                   unused_rid;

    assign unused_rid  = ^rid;
    assign len_p3      = 17'(data_len) + 17'd3;
    assign words_c     = len_p3[16:2];
    assign burst_beats = {1'b0, arlen_q} + 5'd1;
    assign ar_hs       = arvalid_q && arready;
    assign rready_c    = busy_q && !fifo_full;
    assign wr_c        = rvalid && rready_c;
    assign r_end       = wr_c && rlast;
    assign last_c      = (beats_q == words_q - 15'd1);

    // Largest remaining burst class wins: 16, then 8, then 4, then single.
    function automatic logic [3:0] pick_len(input logic [CNT16_W-1:0] c16,
                                            input logic c8, input logic c4);
        if (c16 != '0) return 4'd15;
        if (c8)        return 4'd7;
        if (c4)        return 4'd3;
        return 4'd0;
    endfunction

    always_comb begin
        n16_d = n16_q;
        n8_d  = n8_q;
        n4_d  = n4_q;
        n1_d  = n1_q;
        if (ar_hs) begin
            if (n16_q != '0) n16_d = n16_q - 11'd1;
            else if (n8_q)   n8_d  = 1'b0;
            else if (n4_q)   n4_d  = 1'b0;
            else             n1_d  = n1_q - 2'd1;
        end
        more_d = (n16_d != '0) || n8_d || n4_d || (n1_d != '0);
        case ({ar_hs, r_end})
            2'b10:   out_d = out_q + 3'd1;
            2'b01:   out_d = out_q - 3'd1;
            default: out_d = out_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            rd_done_q <= 1'b0;
            error_q   <= 1'b0;
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arsize_q  <= '0;
            arburst_q <= '0;
            out_q     <= '0;
            n16_q     <= '0;
            n8_q      <= 1'b0;
            n4_q      <= 1'b0;
            n1_q      <= '0;
            words_q   <= '0;
            beats_q   <= '0;
            tail_q    <= '0;
        end else begin
            out_q <= out_d;
            n16_q <= n16_d;
            n8_q  <= n8_d;
            n4_q  <= n4_d;
            n1_q  <= n1_d;
            if (wr_c) begin
                beats_q <= beats_q + 15'd1;
                if (rresp != 2'b00) error_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (mst_begin) begin
                        rd_done_q <= 1'b0;
                        error_q   <= 1'b0;
                        busy_q    <= 1'b1;
                        beats_q   <= '0;
                        words_q   <= words_c;
                        tail_q    <= (data_len[1:0] == 2'b00) ? 3'd4 : {1'b0, data_len[1:0]};
                        n16_q     <= words_c[14:4];
                        n8_q      <= words_c[3];
                        n4_q      <= words_c[2];
                        n1_q      <= words_c[1:0];
                        araddr_q  <= addr_src;
                        arlen_q   <= pick_len(words_c[14:4], words_c[3], words_c[2]);
                        arsize_q  <= 3'b010;
                        arburst_q <= 2'b01;
                        if (data_len == 16'd0) begin
                            state_q <= S_FIN;
                        end else if (addr_src[5:0] != 6'd0) begin
                            error_q <= 1'b1;
                            state_q <= S_FIN;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= S_ADDR;
                        end
                    end
                end
                S_ADDR: begin
                    // Fields advance only on a handshake, so a pending AR stays stable.
                    if (ar_hs) begin
                        araddr_q <= araddr_q + ADDR_WIDTH'({burst_beats, 2'b00});
                        arlen_q  <= pick_len(n16_d, n8_d, n4_d);
                        if (!more_d) begin
                            arvalid_q <= 1'b0;
                            state_q   <= S_WAIT;
                        end else begin
                            arvalid_q <= (out_d < MAX_OUT);
                        end
                    end else if (!arvalid_q) begin
                        arvalid_q <= (out_d < MAX_OUT);
                    end
                end
                S_WAIT: begin
                    if (out_d == '0) state_q <= S_FIN;
                end
                S_FIN: begin
                    rd_done_q <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign rd_done    = rd_done_q;
    assign error      = error_q;
    assign rready     = rready_c;
    assign fifo_wr    = wr_c;
    assign fifo_wdata = rdata;
    assign fifo_last  = wr_c && last_c;
    assign fifo_bytes = !wr_c ? 3'd0 : (last_c ? tail_q : 3'd4);
    assign arvalid    = arvalid_q;
    assign araddr     = araddr_q;
    assign arlen      = arlen_q;
    assign arsize     = arsize_q;
    assign arburst    = arburst_q;
    assign arid       = 4'd0;
    assign arlock     = 2'd0;
    assign arcache    = 4'd0;
    assign arprot     = 3'd0;

endmodule

// File: tb/tb_axi3_mst_read.sv
// Bench for axi3_mst_read: memory slave model, FIFO monitor, vector table
// plus hand-written sequences for outstanding limit, backpressure, errors, reset.
`timescale 1ns/1ps
module tb_axi3_mst_read;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr_src;
    logic [15:0] data_len;
    logic        mst_begin;
    logic        busy, rd_done, error;
    logic        fifo_full;
    logic        fifo_wr, fifo_last;
    logic [31:0] fifo_wdata;
    logic [2:0]  fifo_bytes;
    logic        arready;
    logic [3:0]  arid, arlen, arcache;
    logic [31:0] araddr;
    logic [2:0]  arsize, arprot;
    logic [1:0]  arburst, arlock;
    logic        arvalid;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;

    axi3_mst_read #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(4)) dut (
        .clk(clk), .rst(rst), .addr_src(addr_src), .data_len(data_len),
        .mst_begin(mst_begin), .busy(busy), .rd_done(rd_done), .error(error),
        .fifo_full(fifo_full), .fifo_wr(fifo_wr), .fifo_wdata(fifo_wdata),
        .fifo_last(fifo_last), .fifo_bytes(fifo_bytes), .arready(arready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .rid(rid), .rdata(rdata), .rresp(rresp),
        .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [15:0] len;
        bit          stall;
        int          n_ar;
        int          n_push;
        logic [2:0]  last_b;
        bit          err;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  len;
        int          at_push;
    } ar_t;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic [2:0]  bytes;
    } push_t;

    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    int    last_push_cyc = 0;
    int    done_cyc = 0;
    int    ar_bad = 0;
    int    rr_bad = 0;
    int    beat_i = 0;
    int    beat_g = 0;
    int    err_beat = -1;
    bit    r_en = 1'b1;
    bit    ar_stall = 1'b0;
    bit    toggle_full = 1'b0;
    bit    hold_prev = 1'b0;
    logic [31:0] hold_addr;
    logic [3:0]  hold_len;
    ar_t   ar_log[$];
    ar_t   arq[$];
    push_t push_q[$];
    vec_t  vecs[9];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory slave and FIFO monitor: sample at negedge, drive 1 time unit after posedge.
    initial begin : slave
        ar_t e;
        bit  s_ar, s_r;
        forever begin
            @(negedge clk);
            if (mst_begin) beat_g = 0;
            s_ar = arvalid && arready;
            s_r  = rvalid && rready;
            if (fifo_wr) begin
                push_q.push_back('{fifo_wdata, fifo_last, fifo_bytes});
                last_push_cyc = cyc;
            end
            if (arvalid && (arid != 4'd0 || arsize != 3'b010 || arburst != 2'b01 ||
                            arlock != 2'd0 || arcache != 4'd0 || arprot != 3'd0))
                ar_bad++;
            if (hold_prev && (!arvalid || araddr != hold_addr || arlen != hold_len))
                ar_bad++;
            hold_prev = arvalid && !arready;
            hold_addr = araddr;
            hold_len  = arlen;
            if (rready !== (busy && !fifo_full)) rr_bad++;
            if (s_ar) begin
                e = '{araddr, arlen, push_q.size()};
                ar_log.push_back(e);
                arq.push_back(e);
            end
            @(posedge clk);
            #1;
            if (rst) begin
                arq.delete();
                beat_i    = 0;
                hold_prev = 1'b0;
            end else if (s_r) begin
                beat_g++;
                if (beat_i == int'(arq[0].len)) begin
                    void'(arq.pop_front());
                    beat_i = 0;
                end else begin
                    beat_i++;
                end
            end
            if (!rst && r_en && arq.size() > 0) begin
                rvalid = 1'b1;
                rdata  = pat(arq[0].addr + 32'(beat_i * 4));
                rlast  = (beat_i == int'(arq[0].len));
                rresp  = (beat_g == err_beat) ? 2'b10 : 2'b00;
            end else begin
                rvalid = 1'b0;
                rdata  = '0;
                rlast  = 1'b0;
                rresp  = 2'b00;
            end
            arready   = ar_stall ? 1'($urandom_range(0, 1)) : 1'b1;
            fifo_full = toggle_full ? !fifo_full : 1'b0;
        end
    end

    task automatic start(input logic [31:0] a, input logic [15:0] l);
        ar_log.delete();
        push_q.delete();
        addr_src  = a;
        data_len  = l;
        mst_begin = 1'b1;
        @(posedge clk);
        #1;
        mst_begin = 1'b0;
    endtask

    task automatic wait_done(input string name, input int limit);
        bit ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (rd_done) begin
                ok = 1'b1;
                done_cyc = cyc;
                break;
            end
        end
        check({name, "_timeout"}, 64'(ok), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic verify_pushes(input string name, input logic [31:0] a, input int n,
                                 input logic [2:0] lb);
        int bad = 0;
        bit exp_last;
        check({name, "_push_count"}, 64'(push_q.size()), 64'(n));
        foreach (push_q[k]) begin
            exp_last = (k == n - 1);
            if (push_q[k].data !== pat(a + 32'(k * 4)) || push_q[k].last !== exp_last ||
                push_q[k].bytes !== (exp_last ? lb : 3'd4))
                bad++;
        end
        check({name, "_push_seq"}, 64'(bad), 64'd0);
    endtask

    task automatic check_idle_zero(input string name);
        check({name, "_ctl"}, 64'({busy, rd_done, error, fifo_wr, fifo_last, fifo_bytes,
                                   arvalid, rready, arlen, arsize, arburst, arid, arlock,
                                   arcache, arprot}), 64'd0);
        check({name, "_araddr"}, 64'(araddr), 64'd0);
        check({name, "_wdata"}, 64'(fifo_wdata), 64'd0);
    endtask

    initial begin
        rst = 1'b1; addr_src = '0; data_len = '0; mst_begin = 1'b0;
        fifo_full = 1'b0; arready = 1'b1; rid = 4'd0;
        rdata = '0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;

        vecs[0] = '{32'h0000_1000, 16'd100,  1'b0, 3,  25,  3'd4, 1'b0};
        vecs[1] = '{32'h0000_2000, 16'd7,    1'b0, 2,  2,   3'd3, 1'b0};
        vecs[2] = '{32'h0000_3000, 16'd64,   1'b0, 1,  16,  3'd4, 1'b0};
        vecs[3] = '{32'h0000_4000, 16'd1,    1'b0, 1,  1,   3'd1, 1'b0};
        vecs[4] = '{32'h0000_5000, 16'd0,    1'b0, 0,  0,   3'd0, 1'b0};
        vecs[5] = '{32'h0000_1004, 16'd8,    1'b0, 0,  0,   3'd0, 1'b1};
        vecs[6] = '{32'h0000_6000, 16'd58,   1'b0, 5,  15,  3'd2, 1'b0};
        vecs[7] = '{32'h0000_7000, 16'd1022, 1'b1, 16, 256, 3'd2, 1'b0};
        vecs[8] = '{32'h0000_8040, 16'd30,   1'b0, 1,  8,   3'd2, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        check_idle_zero("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            ar_stall = vecs[i].stall;
            start(vecs[i].addr, vecs[i].len);
            wait_done($sformatf("vec%0d", i), 3000);
            ar_stall = 1'b0;
            check($sformatf("vec%0d_ar_count", i), 64'(ar_log.size()), 64'(vecs[i].n_ar));
            verify_pushes($sformatf("vec%0d", i), vecs[i].addr, vecs[i].n_push, vecs[i].last_b);
            check($sformatf("vec%0d_error", i), 64'(error), 64'(vecs[i].err));
            check($sformatf("vec%0d_done_idle", i), 64'({rd_done, busy}), 64'b10);
            if (vecs[i].n_push > 0)
                check($sformatf("vec%0d_done_lat", i), 64'(done_cyc - last_push_cyc), 64'd2);
            if (i == 0) begin
                check("vec0_ar0", 64'({ar_log[0].addr, ar_log[0].len}), 64'({32'h1000, 4'd15}));
                check("vec0_ar1", 64'({ar_log[1].addr, ar_log[1].len}), 64'({32'h1040, 4'd7}));
                check("vec0_ar2", 64'({ar_log[2].addr, ar_log[2].len}), 64'({32'h1060, 4'd0}));
            end
        end

        // Outstanding limit with the R channel held off
        r_en = 1'b0;
        start(32'h0001_0000, 16'd1024);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("outst_ar_count", 64'(ar_log.size()), 64'd4);
        check("outst_arvalid_low", 64'(arvalid), 64'd0);
        @(posedge clk);
        #1;
        r_en = 1'b1;
        wait_done("outst", 5000);
        check("outst_ar_total", 64'(ar_log.size()), 64'd16);
        check("outst_ar5_after_rlast", 64'(ar_log[4].at_push >= 16), 64'd1);
        verify_pushes("outst", 32'h0001_0000, 256, 3'd4);

        // FIFO backpressure toggling every cycle
        toggle_full = 1'b1;
        start(32'h0000_9000, 16'd64);
        wait_done("full", 3000);
        toggle_full = 1'b0;
        verify_pushes("full", 32'h0000_9000, 16, 3'd4);

        // Error response on the third beat, then cleared by the next start
        err_beat = 2;
        start(32'h0000_A000, 16'd32);
        wait_done("rresp", 3000);
        err_beat = -1;
        check("rresp_error", 64'(error), 64'd1);
        check("rresp_done", 64'(rd_done), 64'd1);
        verify_pushes("rresp", 32'h0000_A000, 8, 3'd4);
        start(32'h0000_A100, 16'd4);
        check("clear_after_begin", 64'({busy, rd_done, error}), 64'b100);
        wait_done("clear", 3000);
        check("clear_error", 64'(error), 64'd0);

        // Misaligned start: error at once, rd_done two cycles after begin
        start(32'h0000_1004, 16'd8);
        check("misal_n1", 64'({busy, rd_done, error, arvalid}), 64'b1010);
        @(posedge clk);
        #1;
        check("misal_n2", 64'({busy, rd_done, error, arvalid}), 64'b0110);
        check("misal_no_ar", 64'(ar_log.size()), 64'd0);

        // Zero-length start
        start(32'h0000_C000, 16'd0);
        @(posedge clk);
        #1;
        check("zero_len", 64'({busy, rd_done, error}), 64'b010);

        // Reset in the middle of a long read
        start(32'h0000_B000, 16'd1024);
        repeat (10) @(posedge clk);
        #1;
        check("midrst_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle_zero("midrst");
        rst = 1'b0;
        @(posedge clk);
        #1;
        start(32'h0000_D000, 16'd16);
        wait_done("post_rst", 3000);
        verify_pushes("post_rst", 32'h0000_D000, 4, 3'd4);

        check("ar_fields_stable", 64'(ar_bad), 64'd0);
        check("rready_tracks", 64'(rr_bad), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
